conv2d: RTL and testbench

- Single-channel 2-D convolution engine with a local input-image RAM and a local output RAM.
- A host loads 8-bit unsigned pixels through a 32-bit write port, sets geometry, stride and kernel, then pulses start.
- The engine slides the kernel over the image, writes one 32-bit result per output position to the output RAM, and raises done.
- Sits as a memory-mapped accelerator leaf under a bus wrapper.

---
 rtl/conv2d_pkg.sv | 18 +
 rtl/conv2d_if.sv | 17 +
 rtl/conv2d_ram.sv | 20 ++
 rtl/conv2d.sv | 154 +++++++++++++++
 tb/tb_conv2d.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and constants for the conv2d convolution engine.
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIX_W = 8;
  localparam int ACC_W = 32;

  function automatic int addr_w(input int dsize);
    return $clog2(dsize) - 2;
  endfunction

endpackage

// File: rtl/conv2d_if.sv
// Host-side bus of conv2d: input-RAM write port, output-RAM read port, start/done.
interface conv2d_if #(
  parameter int AW = conv2d_pkg::addr_w(256)
);
  logic [AW-1:0] mi_addr;
  logic [31:0]   mi_data;
  logic          mi_wr;
  logic [AW-1:0] mo_addr;
  logic [31:0]   mo_data;
  logic          start;
  logic          done;

  modport master (output mi_addr, mi_data, mi_wr, mo_addr, start,
                  input  mo_data, done);
  modport slave  (input  mi_addr, mi_data, mi_wr, mo_addr, start,
                  output mo_data, done);
endinterface

// File: rtl/conv2d_ram.sv
// Single write port RAM with combinational read; contents are never reset.
module conv2d_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/conv2d.sv
// Single-channel 2-D convolution engine: one MAC per cycle, one result word per window.
// Optional macro CONV_SAT8_EN clamps each stored result to 255.
module conv2d
  import conv2d_pkg::*;
#(
  parameter int DSIZE = 256,
  parameter int KSIZE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                data_width,
  input  logic [7:0]                data_hight,
  input  logic [7:0]                di_x_stop,
  input  logic [7:0]                di_y_stop,
  input  logic [3:0]                stride_x,
  input  logic [3:0]                stride_y,
  input  logic [8*KSIZE*KSIZE-1:0]  kernel,
  input  logic [3:0]                kernel_width,
  input  logic [3:0]                kernel_hight,
  conv2d_if.slave                   bus
);
  localparam int AW = addr_w(DSIZE);

  state_t           state_q, state_d;
  logic [3:0]       kx_q, kx_d, ky_q, ky_d;
  logic [7:0]       ox_q, ox_d, oy_q, oy_d;
  logic [AW:0]      n_q, n_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [15:0]      px_x, px_y, px_b;
  logic [31:0]      in_word;
  logic [PIX_W-1:0] pix, coef;
  logic [7:0]       kidx;
  logic [ACC_W-1:0] prod;
  logic [8:0]       ox_nx, oy_nx;
  logic             out_we;
  logic             unused_cfg;

  function automatic logic [ACC_W-1:0] store_val(input logic [ACC_W-1:0] a);
`ifdef CONV_SAT8_EN
    return (a > ACC_W'(255)) ? ACC_W'(255) : a;
`else
    return a;
`endif
  endfunction

  // Window pixel fetch: byte address y*W+x, little-endian lanes within a word
  assign px_x    = 16'(ox_q) + 16'(kx_q);
  assign px_y    = 16'(oy_q) + 16'(ky_q);
  assign px_b    = px_y * 16'(data_width) + px_x;
  assign pix     = PIX_W'(in_word >> {px_b[1:0], 3'b000});
  assign kidx    = 8'(ky_q) * 8'(KSIZE) + 8'(kx_q);
  assign coef    = PIX_W'(kernel >> {kidx, 3'b000});
  assign prod    = ACC_W'(pix) * ACC_W'(coef);
  assign ox_nx   = {1'b0, ox_q} + {5'b0, stride_x};
  assign oy_nx   = {1'b0, oy_q} + {5'b0, stride_y};
  assign out_we  = (state_q == WRITE) && !n_q[AW];
  assign bus.done = (state_q == DONE);
  // Height is implied by di_y_stop; upper address bits fall outside the RAM
  assign unused_cfg = ^{data_hight, px_b};

  conv2d_ram #(.AW(AW), .DW(32)) u_in_ram (
    .clk   (clk),
    .we    (bus.mi_wr),
    .waddr (bus.mi_addr),
    .wdata (bus.mi_data),
    .raddr (px_b[AW+1:2]),
    .rdata (in_word)
  );

  conv2d_ram #(.AW(AW), .DW(32)) u_out_ram (
    .clk   (clk),
    .we    (out_we),
    .waddr (n_q[AW-1:0]),
    .wdata (store_val(acc_q)),
    .raddr (bus.mo_addr),
    .rdata (bus.mo_data)
  );

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    n_d     = n_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = MAC;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          n_d     = '0;
          acc_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        if (kx_q == kernel_width - 4'd1) begin
          kx_d = '0;
          if (ky_q == kernel_hight - 4'd1) begin
            ky_d    = '0;
            state_d = WRITE;
          end else begin
            ky_d = ky_q + 4'd1;
          end
        end else begin
          kx_d = kx_q + 4'd1;
        end
      end
      WRITE: begin
        acc_d = '0;
        // Stop counting once the output RAM is full; later results are dropped
        if (!n_q[AW]) n_d = n_q + {{AW{1'b0}}, 1'b1};
        if (ox_nx > {1'b0, di_x_stop}) begin
          ox_d = '0;
          if (oy_nx > {1'b0, di_y_stop}) begin
            state_d = DONE;
          end else begin
            oy_d    = oy_nx[7:0];
            state_d = MAC;
          end
        end else begin
          ox_d    = ox_nx[7:0];
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      n_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_conv2d.sv
// Scoreboard bench for conv2d: a driver issues runs and queues expected words,
// a monitor reads the output RAM back whenever done rises.
module tb_conv2d;
  import conv2d_pkg::*;

  localparam int DSIZE = 256;
  localparam int KSIZE = 3;
  localparam int AW    = addr_w(DSIZE);
  localparam int NW    = DSIZE / 4;

  typedef struct {
    int          addr;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_width, data_hight, di_x_stop, di_y_stop;
  logic [3:0] stride_x, stride_y, kernel_width, kernel_hight;
  logic [8*KSIZE*KSIZE-1:0] kernel;

  int          total = 0;
  int          bad   = 0;
  byte unsigned img [DSIZE];
  int          kmat [KSIZE][KSIZE];
  exp_t        exp_q [$];
  int          cnt_q [$];
  bit          chk_flag;

  conv2d_if #(.AW(AW)) bus ();

  conv2d #(.DSIZE(DSIZE), .KSIZE(KSIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_width   (data_width),
    .data_hight   (data_hight),
    .di_x_stop    (di_x_stop),
    .di_y_stop    (di_y_stop),
    .stride_x     (stride_x),
    .stride_y     (stride_y),
    .kernel       (kernel),
    .kernel_width (kernel_width),
    .kernel_hight (kernel_hight),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: nested loops over window origins, straight from the convolution definition
  task automatic model(input int w, input int xs, input int ys, input int sx, input int sy,
                       input int kw, input int kh, output int nout);
    int n = 0;
    for (int oy = 0; oy <= ys; oy += sy) begin
      for (int ox = 0; ox <= xs; ox += sx) begin
        longint s = 0;
        exp_t   e;
        for (int ky = 0; ky < kh; ky++)
          for (int kx = 0; kx < kw; kx++)
            s += longint'(img[(oy + ky) * w + ox + kx]) * longint'(kmat[ky][kx]);
`ifdef CONV_SAT8_EN
        if (s > 255) s = 255;
`endif
        if (n < NW) begin
          e.addr = n;
          e.val  = s[31:0];
          exp_q.push_back(e);
        end
        n++;
      end
    end
    cnt_q.push_back((n < NW) ? n : NW);
    nout = n;
  endtask

  task automatic load_image();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      bus.mi_addr = AW'(i);
      bus.mi_data = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      bus.mi_wr   = 1'b1;
    end
    @(negedge clk);
    bus.mi_wr = 1'b0;
  endtask

  task automatic set_cfg(input int w, input int h, input int xs, input int ys,
                         input int sx, input int sy, input int kw, input int kh);
    data_width   = 8'(w);
    data_hight   = 8'(h);
    di_x_stop    = 8'(xs);
    di_y_stop    = 8'(ys);
    stride_x     = 4'(sx);
    stride_y     = 4'(sy);
    kernel_width = 4'(kw);
    kernel_hight = 4'(kh);
    for (int ky = 0; ky < KSIZE; ky++)
      for (int kx = 0; kx < KSIZE; kx++)
        kernel[8*(ky*KSIZE+kx) +: 8] = 8'(kmat[ky][kx]);
  endtask

  task automatic run(input int w, input int h, input int xs, input int ys, input int sx,
                     input int sy, input int kw, input int kh, input bit mid_start);
    int nout, lat, cycles;
    set_cfg(w, h, xs, ys, sx, sy, kw, kh);
    model(w, xs, ys, sx, sy, kw, kh, nout);
    lat = nout * (kw * kh + 1) + 1;
    chk_flag = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 1;
    check("done_after_start", 32'(bus.done), 32'd0);
    while (!bus.done && cycles < lat + 50) begin
      @(posedge clk); #1;
      cycles++;
      bus.start = mid_start && (cycles == 4);
    end
    bus.start = 1'b0;
    check("latency", 32'(cycles), 32'(lat));
    for (int i = 0; i < 2000 && !chk_flag; i++) @(posedge clk);
    if (!chk_flag) begin
      total++;
      bad++;
      $display("FAIL monitor_timeout actual=%0d required=%0d", chk_flag, 1);
      exp_q.delete();
      cnt_q.delete();
    end
  endtask

  task automatic default_setup();
    for (int i = 0; i < DSIZE; i++) img[i] = (i < 64) ? 8'(i) : 8'($urandom);
    for (int ky = 0; ky < KSIZE; ky++) begin
      kmat[ky][0] = 1;
      kmat[ky][1] = 0;
      kmat[ky][2] = 1;
    end
    load_image();
  endtask

  // Monitor: one readback per rising done, popping the queued expectations of that run
  initial begin
    bus.mo_addr = '0;
    forever begin
      @(posedge bus.done);
      #1;
      total++;
      if (cnt_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done actual=%0d required=%0d", 1, 0);
      end else begin
        int n = cnt_q.pop_front();
        for (int i = 0; i < n; i++) begin
          exp_t e = exp_q.pop_front();
          bus.mo_addr = AW'(e.addr);
          #1;
          check($sformatf("word%0d", e.addr), bus.mo_data, e.val);
        end
      end
      chk_flag = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=%0d required=%0d", 1, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mi_addr = '0;
    bus.mi_data = '0;
    bus.mi_wr   = 1'b0;
    bus.start   = 1'b0;
    for (int ky = 0; ky < KSIZE; ky++)
      for (int kx = 0; kx < KSIZE; kx++) kmat[ky][kx] = 0;
    set_cfg(8, 8, 5, 5, 1, 1, 3, 3);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    default_setup();
    run(8, 8, 5, 5, 1, 1, 3, 3, 1'b1);   // default, with ignored start mid-run
    run(8, 8, 4, 4, 2, 2, 3, 3, 1'b0);   // stride 2, restart from DONE
    run(8, 8, 0, 5, 1, 1, 3, 3, 1'b0);   // single column
    run(8, 8, 5, 0, 1, 1, 3, 3, 1'b0);   // single row

    for (int ky = 0; ky < KSIZE; ky++)
      for (int kx = 0; kx < KSIZE; kx++) kmat[ky][kx] = (ky == 0 && kx == 0) ? 5 : 7;
    run(8, 8, 7, 7, 1, 1, 1, 1, 1'b0);   // 1x1 kernel fills all 64 words

    for (int i = 0; i < DSIZE; i++) img[i] = 8'hFF;
    for (int ky = 0; ky < KSIZE; ky++)
      for (int kx = 0; kx < KSIZE; kx++) kmat[ky][kx] = 255;
    load_image();
    run(8, 8, 5, 5, 1, 1, 3, 3, 1'b0);   // max-value accumulation

    // Reset in the middle of a run, then confirm the engine sits idle
    default_setup();
    set_cfg(8, 8, 5, 5, 1, 1, 3, 3);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("idle_after_reset", 32'(bus.done), 32'd0);
    run(8, 8, 5, 5, 1, 1, 3, 3, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int kw = $urandom_range(1, 3);
      int kh = $urandom_range(1, 3);
      int w  = $urandom_range(kw, 16);
      int h  = $urandom_range(kh, 16);
      for (int i = 0; i < DSIZE; i++) img[i] = 8'($urandom);
      for (int ky = 0; ky < KSIZE; ky++)
        for (int kx = 0; kx < KSIZE; kx++) kmat[ky][kx] = int'($urandom_range(0, 255));
      load_image();
      run(w, h, $urandom_range(0, w - kw), $urandom_range(0, h - kh),
          $urandom_range(1, 4), $urandom_range(1, 4), kw, kh, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
